// File: rtl/mbs_inst_fetch_pkg.sv
// Shared MBScore constants for the instruction fetch unit: data width, PC step,
// FSM state encoding and the FIFO entry layout.
package mbs_inst_fetch_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDrop = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] inst;
        logic [DATA_WIDTH-1:0] pc;
    } fetch_entry_t;

    function automatic logic [DATA_WIDTH-1:0] align_pc(input logic [DATA_WIDTH-1:0] pc);
        return {pc[DATA_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mbs_inst_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack, decode valid/ready and redirect.
// The master modport is the fetch unit; the slave modport is memory plus core.
interface mbs_inst_fetch_if;
    import mbs_inst_fetch_pkg::*;

    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  inst_valid;
    logic [DATA_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] inst_pc;
    logic                  inst_ready;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/mbs_sync_fifo.sv
// Show-ahead synchronous FIFO with a synchronous flush; the head word is read straight
// from storage so data_o/valid_o carry no combinational path from pop_i.
module mbs_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, empty, do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty;

    // Flush wins over any same-cycle push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '{default: '0};
        end else if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = !empty;
    assign count_o = count_q;

endmodule

// File: rtl/mbs_inst_fetch.sv
// MBScore instruction fetch: single-outstanding sequential reads into a prefetch FIFO,
// with redirect flushing the FIFO and discarding any read still in flight.
module mbs_inst_fetch
    import mbs_inst_fetch_pkg::*;
#(
    parameter int unsigned           DEPTH    = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mbs_inst_fetch_if.master bus_io
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] req_addr_q, req_addr_d;

    logic                  fifo_push, fifo_pop, fifo_flush;
    logic                  head_valid;
    logic [CW-1:0]         fifo_count;
    fetch_entry_t          push_entry, head_entry;
    logic                  can_issue;

    // Count cannot grow while a read is outstanding, so this check alone prevents overflow.
    assign can_issue = (fifo_count < CW'(DEPTH));

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        fifo_push  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!bus_io.redirect_valid && can_issue) begin
                    state_d    = StWait;
                    req_addr_d = fetch_pc_q;
                end
            end
            StWait: begin
                if (bus_io.redirect_valid) begin
                    state_d = bus_io.imem_ack ? StIdle : StDrop;
                end else if (bus_io.imem_ack) begin
                    fifo_push  = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_INC;
                    state_d    = StIdle;
                end
            end
            StDrop: begin
                if (bus_io.imem_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus_io.redirect_valid) begin
            fetch_pc_d = align_pc(bus_io.redirect_pc);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign fifo_flush = bus_io.redirect_valid;
    assign fifo_pop   = bus_io.inst_ready && !bus_io.redirect_valid;
    assign push_entry = '{inst: bus_io.imem_rdata, pc: req_addr_q};

    mbs_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_prefetch_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .data_i  (push_entry),
        .pop_i   (fifo_pop),
        .data_o  (head_entry),
        .valid_o (head_valid),
        .count_o (fifo_count)
    );

    assign bus_io.imem_req   = (state_q != StIdle);
    assign bus_io.imem_addr  = req_addr_q;
    assign bus_io.inst_valid = head_valid;
    assign bus_io.inst       = head_entry.inst;
    assign bus_io.inst_pc    = head_entry.pc;

endmodule

// File: tb/tb_mbs_inst_fetch.sv
// Self-checking bench for mbs_inst_fetch: directed scenarios plus a randomized run,
// checked against a stream-level model (next expected PC, buffered-word count).
module tb_mbs_inst_fetch;
    import mbs_inst_fetch_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic clk;
    logic rst1;
    logic rst2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mbs_inst_fetch_if bus ();
    mbs_inst_fetch_if bus2 ();

    mbs_inst_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst1),
        .bus_io (bus)
    );

    mbs_inst_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'hFFFF_FFFC)
    ) dut2 (
        .clk_i  (clk),
        .rst_i  (rst2),
        .bus_io (bus2)
    );

    int           tests;
    int           fails;
    int           occ;
    int           cnt_left;
    int           dmin;
    int           dmax;
    int           issues;
    int           consumed;
    bit           busy;
    bit           drop_cur;
    logic [31:0]  exp_pc;
    logic [31:0]  req_expect;
    logic [31:0]  cur_addr;
    logic [31:0]  issued_q[$];
    logic [31:0]  q2[$];
    logic [31:0]  p2[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'h0021_0820 ^ (a * 32'h0001_0001);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        occ        = 0;
        exp_pc     = 32'h0;
        req_expect = 32'h0;
        busy       = 1'b0;
        drop_cur   = 1'b0;
        cnt_left   = 0;
        issues     = 0;
        consumed   = 0;
        issued_q.delete();
    endtask

    task automatic drive_idle();
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
    endtask

    // Entered 1 time unit after a rising edge; leaves 1 time unit after the next one.
    task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc);
        bit ack;
        ack = 1'b0;
        chk("valid", 32'(bus.inst_valid), (occ != 0) ? 32'd1 : 32'd0);
        if (busy) chk("req_held", 32'(bus.imem_req), 32'd1);
        if (bus.imem_req) begin
            if (!busy) begin
                chk("issue_addr", bus.imem_addr, req_expect);
                issued_q.push_back(bus.imem_addr);
                issues++;
                busy     = 1'b1;
                drop_cur = 1'b0;
                cur_addr = bus.imem_addr;
                cnt_left = $urandom_range(dmax, dmin);
            end else begin
                chk("addr_stable", bus.imem_addr, cur_addr);
            end
            if (cnt_left == 0) ack = 1'b1;
            else cnt_left--;
        end
        bus.imem_ack       = ack;
        bus.imem_rdata     = ack ? word_of(cur_addr) : $urandom;
        bus.inst_ready     = rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        if (!redir && rdy && occ != 0) begin
            chk("inst_pc", bus.inst_pc, exp_pc);
            chk("inst", bus.inst, word_of(exp_pc));
            exp_pc += 32'd4;
            occ--;
            consumed++;
        end
        if (ack && !drop_cur && !redir) begin
            occ++;
            req_expect += 32'd4;
        end
        if (redir) begin
            occ        = 0;
            exp_pc     = {rpc[31:2], 2'b00};
            req_expect = exp_pc;
            if (busy && !ack) drop_cur = 1'b1;
        end
        if (ack) busy = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut1();
        drive_idle();
        #2 rst1 = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        #2 rst1 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int idx;
        bit ack2;
        tests = 0;
        fails = 0;
        dmin  = 0;
        dmax  = 0;
        rst1  = 1'b1;
        rst2  = 1'b1;
        drive_idle();
        bus2.imem_ack       = 1'b0;
        bus2.imem_rdata     = 32'h0;
        bus2.inst_ready     = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = 32'h0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        #2 rst1 = 1'b0;
        @(posedge clk);
        #1;
        chk("req_cycle1", 32'(bus.imem_req), 32'd1);

        // Ack one cycle after request, consumer always ready.
        dmin = 1;
        dmax = 1;
        repeat (12) cycle(1'b1, 1'b0, $urandom);
        chk("t1_issues", 32'(issues), 32'd4);
        chk("t1_consumed", 32'(consumed), 32'd4);
        chk("t1_addr0", issued_q[0], 32'h0);
        chk("t1_addr1", issued_q[1], 32'h4);
        chk("t1_addr2", issued_q[2], 32'h8);

        // Stalled consumer, zero-wait memory: FIFO fills then fetch stops.
        reset_dut1();
        dmin = 0;
        dmax = 0;
        repeat (10) cycle(1'b0, 1'b0, $urandom);
        chk("t2_issues", 32'(issues), 32'd2);
        chk("t2_req_low", 32'(bus.imem_req), 32'd0);
        cycle(1'b1, 1'b0, $urandom);
        repeat (10) cycle(1'b0, 1'b0, $urandom);
        chk("t2_one_more", 32'(issues), 32'd3);

        // Redirect while a slow read is outstanding.
        reset_dut1();
        dmin = 3;
        dmax = 3;
        n = 0;
        while (!(busy && cnt_left >= 1) && n < 20) begin
            cycle(1'b1, 1'b0, $urandom);
            n++;
        end
        chk("t3_reach_wait", 32'(busy && cnt_left >= 1), 32'd1);
        cycle(1'b1, 1'b1, 32'h0000_0103);
        repeat (15) cycle(1'b1, 1'b0, $urandom);
        chk("t3_next_addr", issued_q[1], 32'h0000_0100);
        chk("t3_progress", 32'(consumed > 0), 32'd1);

        // Redirect coinciding with ack and a pop.
        reset_dut1();
        dmin = 0;
        dmax = 0;
        n = 0;
        while (!(occ != 0 && bus.imem_req && !busy) && n < 20) begin
            cycle(1'b0, 1'b0, $urandom);
            n++;
        end
        chk("t4_reach", 32'(occ != 0 && bus.imem_req && !busy), 32'd1);
        idx = issued_q.size();
        cycle(1'b1, 1'b1, 32'h0000_0200);
        chk("t4_empty", 32'(bus.inst_valid), 32'd0);
        repeat (6) cycle(1'b1, 1'b0, $urandom);
        chk("t4_next_addr", issued_q[idx+1], 32'h0000_0200);

        // Asynchronous reset mid-read, then a late ack while idle.
        reset_dut1();
        dmin = 1;
        dmax = 1;
        n = 0;
        while (!(occ != 0 && busy) && n < 20) begin
            cycle(1'b0, 1'b0, $urandom);
            n++;
        end
        chk("t5_reach", 32'(occ != 0 && busy), 32'd1);
        #2 rst1 = 1'b1;
        #1;
        chk("t5_req", 32'(bus.imem_req), 32'd0);
        chk("t5_valid", 32'(bus.inst_valid), 32'd0);
        chk("t5_inst", bus.inst, 32'd0);
        chk("t5_inst_pc", bus.inst_pc, 32'd0);
        #3;
        model_reset();
        dmin = 0;
        dmax = 0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        rst1 = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_late_ack_valid", 32'(bus.inst_valid), 32'd0);
        chk("t5_late_ack_req", 32'(bus.imem_req), 32'd1);
        repeat (10) cycle(1'b1, 1'b0, $urandom);

        // Randomized traffic.
        reset_dut1();
        dmin = 0;
        dmax = 3;
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
        end
        chk("rand_progress", 32'(consumed > 100), 32'd1);

        // Wrap from the top of the address space on the second instance.
        drive_idle();
        #2 rst1 = 1'b1;
        rst2 = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            ack2 = bus2.imem_req;
            if (ack2) q2.push_back(bus2.imem_addr);
            if (bus2.inst_valid) p2.push_back(bus2.inst_pc);
            bus2.imem_ack   = ack2;
            bus2.imem_rdata = word_of(bus2.imem_addr);
            @(posedge clk);
            #1;
        end
        chk("t6_count", 32'(q2.size() >= 2 && p2.size() >= 2), 32'd1);
        chk("t6_addr0", q2[0], 32'hFFFF_FFFC);
        chk("t6_addr1", q2[1], 32'h0000_0000);
        chk("t6_pc0", p2[0], 32'hFFFF_FFFC);
        chk("t6_pc1", p2[1], 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mbs_inst_fetch.md
# mbs_inst_fetch

Instruction fetch unit for MBScore. It generates sequential fetch addresses and issues single-outstanding reads to instruction memory over a req/ack handshake. Returned words are buffered in a small prefetch FIFO and presented to the core's decode stage over a valid/ready interface. A branch/jump redirect from the core flushes the buffer and discards any read still in flight.

## Interface
- `DEPTH`, 2: prefetch FIFO entries (power of two, ≥2)
- `RESET_PC`, 32'h0000_0000: first fetch address after reset
- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  read request; held high until `imem_ack`
- `imem_addr`  out  `DATA_WIDTH`  word address of the outstanding read; stable while `imem_req`
- `imem_ack`  in  1  one-cycle pulse; `imem_rdata` valid this cycle
- `imem_rdata`  in  `DATA_WIDTH`  instruction word
- `inst_valid`  out  1  FIFO head is valid
- `inst`  out  `DATA_WIDTH`  FIFO head instruction
- `inst_pc`  out  `DATA_WIDTH`  address of `inst`
- `inst_ready`  in  1  core consumes head when `inst_valid && inst_ready`
- `redirect_valid`  in  1  one-cycle pulse: restart fetch at `redirect_pc`
- `redirect_pc`  in  `DATA_WIDTH`  new fetch address; bits [1:0] forced to 0

## Operation
- Registers: `fetch_pc`, `req_addr`, `state`, FIFO (data + pc per entry), `count`.
- States:
  - IDLE: no read outstanding.
  - WAIT: read outstanding, result kept.
  - DROP: read outstanding, result discarded.
- `imem_req = (state != IDLE)`; `imem_addr = req_addr`.
- IDLE → WAIT when `count < DEPTH` and no redirect this cycle. Action: `req_addr <= fetch_pc`.
- WAIT, `imem_ack`, no redirect: push {`imem_rdata`, `req_addr`}, `fetch_pc += 4`, → IDLE.
- WAIT, redirect without ack → DROP. WAIT, redirect with ack → IDLE, data not pushed.
- DROP, `imem_ack` → IDLE, data not pushed. The request stays asserted in DROP; the memory handshake is never abandoned.
- Redirect, in any state:
  - FIFO flushed (`count <= 0`); `inst_valid` is low the next cycle.
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - Redirect takes priority over a same-cycle pop or push.
  - Redirect in DROP updates `fetch_pc` and stays in DROP.
- FIFO: show-ahead. Push and pop in the same cycle leave `count` unchanged. A pop while empty is ignored. A push while full cannot occur, because issue requires `count < DEPTH` and `count` never increases while a read is outstanding.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Reset values: `state`=IDLE, `fetch_pc`=`RESET_PC`, `req_addr`=`RESET_PC`, `count`=0. Outputs: `imem_req`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0 (FIFO storage cleared).
- Reset mid-transaction returns to IDLE immediately. A late `imem_ack` arriving in IDLE is ignored.

## Timing
- Cycle 0 is the first edge after `rst` falls: `state`→WAIT; `imem_req` is high in cycle 1.
- With a zero-wait memory (ack in the first request cycle): `inst_valid` goes high the cycle after the ack. Steady-state throughput is one instruction per 2 cycles.
- With an N-cycle ack delay, fetch-to-valid latency is N+1 cycles.
- Redirect to the first request at the new PC: 1 cycle from IDLE. From WAIT/DROP it is ack cycle + 1.
- `inst`, `inst_pc`, and `inst_valid` are driven directly from registers; there is no combinational path from `inst_ready`.

## Structure
- `DATA_WIDTH`, the PC increment (4), and the state encodings go in the shared MBScore constants include.
- One sub-module: `mbs_sync_fifo`, with parameterised width/depth, a synchronous flush, and show-ahead read. It is instantiated with width 2×`DATA_WIDTH`. The FSM and PC logic stay in the top.

## Test plan
- Reset release, memory acks 1 cycle after req, `inst_ready`=1:
  - `imem_addr` sequence is 0, 4, 8.
  - `inst_pc` matches, `inst` equals the returned words (e.g. 32'h0021_0820).
- `inst_ready`=0, zero-wait memory:
  - exactly `DEPTH` (2) reads are issued, then `imem_req` stays low.
  - Raising `inst_ready` for 1 cycle causes exactly one more read.
- Redirect to 32'h0000_0103 while WAIT:
  - `imem_req` stays high until ack; the acked word never appears on `inst`.
  - The next `imem_addr` is 32'h0000_0100.
- Redirect in the same cycle as `imem_ack` and `inst_ready`:
  - FIFO empty next cycle, ack data dropped, next request at the redirect address.
- Start at `RESET_PC`=32'hFFFF_FFFC: addresses go FFFF_FFFC, then 0000_0000.
- Assert `rst` while WAIT:
  - all outputs reach reset values with no clock edge.
  - A late `imem_ack` produces no push.
